// File: rtl/hilo_ctrl.sv
// hilo_ctrl -- execute-stage controller for the MIPS HI/LO instruction class.
//
// Decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO, hands latched operands to
// the mult_div unit, stalls EX until the unit reports ready, then commits the
// 64-bit result into the architectural HI/LO registers. A flush cancels any
// in-flight operation and spends one ABORT cycle with the enable low so the
// unit can clear itself.
//
// Optional feature: define HILO_ACC_EN to add MADD/MADDU/MSUB/MSUBU
// (ops 8-11), which multiply and then accumulate into / subtract from HI:LO.
// Without the macro, ops 8-11 are treated as reserved.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   op_valid, op         EX holds a HI/LO-class instruction / its opcode
//   src_a, src_b         rs / rt operand values
//   flush                cancel the EX instruction and any in-flight op
//   stall_ex             hold the EX stage
//   md_a, md_b           registered operands to mult_div
//   md_mult, md_signed   operation kind (1 = multiply) and signedness
//   md_enable            start/hold enable to mult_div
//   md_res_h, md_res_l   mult_div result
//   md_ready             mult_div result valid
//   hi_o, lo_o           architectural HI/LO registers
//   rd_data              MFHI/MFLO read data
//   busy                 controller is not idle
module hilo_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              flush,
    output logic              stall_ex,
    output logic [DATA_W-1:0] md_a,
    output logic [DATA_W-1:0] md_b,
    output logic              md_mult,
    output logic              md_signed,
    output logic              md_enable,
    input  logic [DATA_W-1:0] md_res_h,
    input  logic [DATA_W-1:0] md_res_l,
    input  logic              md_ready,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy
);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MFHI  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd10;

    typedef enum logic [1:0] {IDLE, CALC, ABORT} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [DATA_W-1:0]   mdA_q, mdA_d, mdB_q, mdB_d;
    logic                mdMult_q, mdMult_d, mdSigned_q, mdSigned_d;
    logic                mdEnable_q, mdEnable_d;

    logic                isMulDiv, isAccOp, isMdOp, isMove;
    logic [2*DATA_W-1:0] mdResult, commitVal;

`ifdef HILO_ACC_EN
    // The accumulate flavour must be remembered because EX may present a
    // different opcode by the time the result comes back.
    logic [3:0]          op_q, op_d;
`endif

    // Instruction class decode.
    always_comb begin
        isMulDiv = (op[3:2] == 2'b00);
        isMove   = (op[3:2] == 2'b01);
`ifdef HILO_ACC_EN
        isAccOp  = (op[3:2] == 2'b10);
`else
        isAccOp  = 1'b0;
`endif
        isMdOp   = isMulDiv | isAccOp;
    end

    // Value written into HI:LO when the unit reports ready; accumulate
    // variants wrap modulo 2^(2*DATA_W).
    always_comb begin
        mdResult  = {md_res_h, md_res_l};
        commitVal = mdResult;
`ifdef HILO_ACC_EN
        if (op_q[3:1] == 3'b100) begin
            commitVal = {hi_q, lo_q} + mdResult;
        end else if (op_q[3:1] == 3'b101) begin
            commitVal = {hi_q, lo_q} - mdResult;
        end
`endif
    end

    // Next-state, register updates and the combinational stall. In CALC a
    // flush beats md_ready so a cancelled operation never commits.
    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        mdA_d      = mdA_q;
        mdB_d      = mdB_q;
        mdMult_d   = mdMult_q;
        mdSigned_d = mdSigned_q;
        mdEnable_d = mdEnable_q;
        stall_ex   = 1'b0;
`ifdef HILO_ACC_EN
        op_d       = op_q;
`endif
        case (state_q)
            IDLE: begin
                if (op_valid && !flush) begin
                    if (isMdOp) begin
                        stall_ex   = 1'b1;
                        mdA_d      = src_a;
                        mdB_d      = src_b;
                        mdMult_d   = !((op == OP_DIV) || (op == OP_DIVU));
                        mdSigned_d = (op == OP_MULT) || (op == OP_DIV) ||
                                     (op == OP_MADD) || (op == OP_MSUB);
                        mdEnable_d = 1'b1;
                        state_d    = CALC;
`ifdef HILO_ACC_EN
                        op_d       = op;
`endif
                    end else if (op == OP_MTHI) begin
                        hi_d = src_a;
                    end else if (op == OP_MTLO) begin
                        lo_d = src_a;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    mdEnable_d = 1'b0;
                    state_d    = ABORT;
                end else if (md_ready) begin
                    {hi_d, lo_d} = commitVal;
                    mdEnable_d   = 1'b0;
                    state_d      = IDLE;
                end else begin
                    stall_ex = 1'b1;
                end
            end
            ABORT: begin
                mdEnable_d = 1'b0;
                state_d    = IDLE;
                stall_ex   = op_valid && !flush && (isMdOp || isMove);
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and register bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            mdA_q      <= '0;
            mdB_q      <= '0;
            mdMult_q   <= 1'b0;
            mdSigned_q <= 1'b0;
            mdEnable_q <= 1'b0;
`ifdef HILO_ACC_EN
            op_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            mdA_q      <= mdA_d;
            mdB_q      <= mdB_d;
            mdMult_q   <= mdMult_d;
            mdSigned_q <= mdSigned_d;
            mdEnable_q <= mdEnable_d;
`ifdef HILO_ACC_EN
            op_q       <= op_d;
`endif
        end
    end

    assign md_a      = mdA_q;
    assign md_b      = mdB_q;
    assign md_mult   = mdMult_q;
    assign md_signed = mdSigned_q;
    assign md_enable = mdEnable_q;
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;
    assign rd_data   = (op == OP_MFHI) ? hi_q : lo_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl -- self-checking bench for hilo_ctrl.
//
// A directed vector table, hand-written multi-cycle sequences (long divide,
// flush with abort, reset mid-operation, accumulate) and a randomized run.
// A behavioural model tracks HI:LO as one 64-bit value plus the pending
// operation; the bench also plays the mult_div unit with plain arithmetic.
// Honours HILO_ACC_EN the same way the design does.
module tb_hilo_ctrl;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst, op_valid, flush, md_ready;
    logic [3:0]    op;
    logic [W-1:0]  src_a, src_b, md_res_h, md_res_l;
    logic          stall_ex, md_mult, md_signed, md_enable, busy;
    logic [W-1:0]  md_a, md_b, hi_o, lo_o, rd_data;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    hilo_ctrl #(.DATA_W(W)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
        .src_a(src_a), .src_b(src_b), .flush(flush), .stall_ex(stall_ex),
        .md_a(md_a), .md_b(md_b), .md_mult(md_mult), .md_signed(md_signed),
        .md_enable(md_enable), .md_res_h(md_res_h), .md_res_l(md_res_l),
        .md_ready(md_ready), .hi_o(hi_o), .lo_o(lo_o), .rd_data(rd_data),
        .busy(busy)
    );

    // Reference model state.
    typedef enum {P_IDLE, P_CALC, P_ABORT} phase_t;
    phase_t        mPhase;
    logic [63:0]   mHiLo;
    logic [31:0]   mA, mB;
    logic          mMult, mSigned, mEn;
    logic [3:0]    mOp;

    logic          sampStall;
    logic [31:0]   sampRd;

    typedef struct {
        logic        r, v;
        logic [3:0]  o;
        logic [31:0] a, b;
        logic        fl, rdy;
        logic [31:0] rh, rl;
        logic        eStall;
        logic [31:0] eRd, eHi, eLo;
    } vec_t;

    vec_t vecs[11];

    function automatic logic isMdOp(input logic [3:0] o);
        logic res;
        res = (o <= 4'd3);
`ifdef HILO_ACC_EN
        res = res || (o >= 4'd8 && o <= 4'd11);
`endif
        return res;
    endfunction

    // Behavioural mult_div: {HI, LO} = product, or {remainder, quotient}.
    function automatic logic [63:0] mdCompute(input logic m, input logic s,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (m) begin
            if (s) return 64'(sa * sb);
            return {32'd0, a} * {32'd0, b};
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) return {32'(sa % sb), 32'(sa / sb)};
        return {a % b, a / b};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, check combinational outputs before the
    // edge, advance the model across the edge, then check registered outputs.
    task automatic applyStimulus(input logic r, input logic v,
                                 input logic [3:0] o,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic fl, input logic rdy,
                                 input logic [31:0] rh, input logic [31:0] rl);
        logic        eStall;
        logic [63:0] res;
        rst = r; op_valid = v; op = o; src_a = a; src_b = b;
        flush = fl; md_ready = rdy; md_res_h = rh; md_res_l = rl;
        #1;
        case (mPhase)
            P_IDLE:  eStall = v && isMdOp(o) && !fl;
            P_CALC:  eStall = !fl && !rdy;
            default: eStall = v && !fl && (isMdOp(o) || (o >= 4'd4 && o <= 4'd7));
        endcase
        sampStall = stall_ex;
        sampRd    = rd_data;
        checkOutput("stall_ex", 64'(stall_ex), 64'(eStall));
        checkOutput("rd_data", 64'(rd_data), (o == 4'd6) ? 64'(mHiLo[63:32]) : 64'(mHiLo[31:0]));
        @(posedge clk);
        if (r) begin
            mPhase = P_IDLE; mHiLo = 64'd0; mA = 32'd0; mB = 32'd0;
            mMult = 1'b0; mSigned = 1'b0; mEn = 1'b0; mOp = 4'd0;
        end else if (mPhase == P_IDLE) begin
            if (v && !fl) begin
                if (isMdOp(o)) begin
                    mA = a; mB = b; mOp = o; mEn = 1'b1; mPhase = P_CALC;
                    mMult   = !(o == 4'd2 || o == 4'd3);
                    mSigned = (o == 4'd0 || o == 4'd2 || o == 4'd8 || o == 4'd10);
                end else if (o == 4'd4) begin
                    mHiLo[63:32] = a;
                end else if (o == 4'd5) begin
                    mHiLo[31:0] = a;
                end
            end
        end else if (mPhase == P_CALC) begin
            if (fl) begin
                mEn = 1'b0; mPhase = P_ABORT;
            end else if (rdy) begin
                res = {rh, rl};
                if (mOp == 4'd8 || mOp == 4'd9)        mHiLo = mHiLo + res;
                else if (mOp == 4'd10 || mOp == 4'd11) mHiLo = mHiLo - res;
                else                                   mHiLo = res;
                mEn = 1'b0; mPhase = P_IDLE;
            end
        end else begin
            mPhase = P_IDLE;
        end
        #1;
        checkOutput("hi_o", 64'(hi_o), 64'(mHiLo[63:32]));
        checkOutput("lo_o", 64'(lo_o), 64'(mHiLo[31:0]));
        checkOutput("busy", 64'(busy), 64'(mPhase != P_IDLE));
        checkOutput("md_enable", 64'(md_enable), 64'(mEn));
        checkOutput("md_a", 64'(md_a), 64'(mA));
        checkOutput("md_b", 64'(md_b), 64'(mB));
        checkOutput("md_mult", 64'(md_mult), 64'(mMult));
        checkOutput("md_signed", 64'(md_signed), 64'(mSigned));
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        int          stallCnt;
        logic        r, v, fl, rdy;
        logic [3:0]  o;
        logic [31:0] a, b;
        logic [63:0] res;

        // Fields: r, v, op, a, b, flush, ready, resH, resL, stall, rd, hi, lo
        vecs[0]  = '{1'b1, 1'b0, 4'd0,  32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                     1'b0, 32'h0, 32'h0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 4'd0,  32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, 32'h0, 32'h0,
                     1'b1, 32'h0, 32'h0, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 4'd0,  32'hFFFF_FFFD, 32'd5, 1'b0, 1'b1,
                     32'hFFFF_FFFF, 32'hFFFF_FFF1,
                     1'b0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[3]  = '{1'b0, 1'b1, 4'd4,  32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                     1'b0, 32'hFFFF_FFF1, 32'hDEAD_BEEF, 32'hFFFF_FFF1};
        vecs[4]  = '{1'b0, 1'b1, 4'd6,  32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                     1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hFFFF_FFF1};
        vecs[5]  = '{1'b0, 1'b1, 4'd5,  32'h1111_1111, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0,
                     1'b0, 32'hFFFF_FFF1, 32'hDEAD_BEEF, 32'hFFFF_FFF1};
        vecs[6]  = '{1'b0, 1'b1, 4'd5,  32'h5678, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                     1'b0, 32'hFFFF_FFF1, 32'hDEAD_BEEF, 32'h5678};
        vecs[7]  = '{1'b0, 1'b1, 4'd4,  32'h1234, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                     1'b0, 32'h5678, 32'h1234, 32'h5678};
        vecs[8]  = '{1'b0, 1'b1, 4'd12, 32'hAAAA, 32'hBBBB, 1'b0, 1'b0, 32'h0, 32'h0,
                     1'b0, 32'h5678, 32'h1234, 32'h5678};
        vecs[9]  = '{1'b0, 1'b1, 4'd7,  32'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF, 32'hFFFF,
                     1'b0, 32'h5678, 32'h1234, 32'h5678};
        vecs[10] = '{1'b0, 1'b1, 4'd0,  32'd3, 32'd3, 1'b1, 1'b0, 32'h0, 32'h0,
                     1'b0, 32'h5678, 32'h1234, 32'h5678};

        // Bring the design out of power-up before anything is compared.
        rst = 1'b1; op_valid = 1'b0; op = 4'd0; src_a = '0; src_b = '0;
        flush = 1'b0; md_ready = 1'b0; md_res_h = '0; md_res_l = '0;
        repeat (2) @(posedge clk);
        #1;
        mPhase = P_IDLE; mHiLo = 64'd0; mA = 32'd0; mB = 32'd0;
        mMult = 1'b0; mSigned = 1'b0; mEn = 1'b0; mOp = 4'd0;

        $display("[TB] directed vector table");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].r, vecs[i].v, vecs[i].o, vecs[i].a, vecs[i].b,
                          vecs[i].fl, vecs[i].rdy, vecs[i].rh, vecs[i].rl);
            checkOutput($sformatf("vec%0d_stall", i), 64'(sampStall), 64'(vecs[i].eStall));
            checkOutput($sformatf("vec%0d_rd", i), 64'(sampRd), 64'(vecs[i].eRd));
            checkOutput($sformatf("vec%0d_hi", i), 64'(hi_o), 64'(vecs[i].eHi));
            checkOutput($sformatf("vec%0d_lo", i), 64'(lo_o), 64'(vecs[i].eLo));
        end

        $display("[TB] DIVU 100/7 with 33-cycle latency");
        stallCnt = 0;
        for (int c = 0; c < 33; c++) begin
            applyStimulus(1'b0, 1'b1, 4'd3, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0, 32'd0);
            stallCnt += int'(sampStall);
        end
        applyStimulus(1'b0, 1'b1, 4'd3, 32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 32'd14);
        stallCnt += int'(sampStall);
        checkOutput("divu_stall_cycles", 64'(stallCnt), 64'd33);
        checkOutput("divu_hi", 64'(hi_o), 64'd2);
        checkOutput("divu_lo", 64'(lo_o), 64'd14);

        $display("[TB] DIV flushed mid-operation, MULTU arriving in ABORT");
        applyStimulus(1'b0, 1'b1, 4'd4, 32'h1234, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        applyStimulus(1'b0, 1'b1, 4'd5, 32'h5678, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int c = 0; c < 10; c++)
            applyStimulus(1'b0, 1'b1, 4'd2, 32'd50, 32'd3, 1'b0, 1'b0, 32'd0, 32'd0);
        applyStimulus(1'b0, 1'b1, 4'd2, 32'd50, 32'd3, 1'b1, 1'b1, 32'd2, 32'd16);
        checkOutput("flush_md_enable", 64'(md_enable), 64'd0);
        checkOutput("flush_busy", 64'(busy), 64'd1);
        applyStimulus(1'b0, 1'b1, 4'd1, 32'd3, 32'd4, 1'b0, 1'b0, 32'd0, 32'd0);
        checkOutput("abort_stall", 64'(sampStall), 64'd1);
        checkOutput("abort_hi", 64'(hi_o), 64'h1234);
        checkOutput("abort_lo", 64'(lo_o), 64'h5678);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        applyStimulus(1'b0, 1'b1, 4'd1, 32'd3, 32'd4, 1'b0, 1'b0, 32'd0, 32'd0);
        applyStimulus(1'b0, 1'b1, 4'd1, 32'd3, 32'd4, 1'b0, 1'b1, 32'd0, 32'd12);
        checkOutput("multu_hi", 64'(hi_o), 64'd0);
        checkOutput("multu_lo", 64'(lo_o), 64'd12);

        $display("[TB] reset during DIV");
        applyStimulus(1'b0, 1'b1, 4'd2, 32'd9, 32'd2, 1'b0, 1'b0, 32'd0, 32'd0);
        applyStimulus(1'b0, 1'b1, 4'd2, 32'd9, 32'd2, 1'b0, 1'b0, 32'd0, 32'd0);
        applyStimulus(1'b1, 1'b1, 4'd2, 32'd9, 32'd2, 1'b0, 1'b1, 32'd7, 32'd7);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_md_enable", 64'(md_enable), 64'd0);
        checkOutput("rst_hilo", {hi_o, lo_o}, 64'd0);
        applyStimulus(1'b0, 1'b1, 4'd0, 32'd2, 32'd2, 1'b0, 1'b0, 32'd0, 32'd0);
        applyStimulus(1'b0, 1'b1, 4'd0, 32'd2, 32'd2, 1'b0, 1'b1, 32'd0, 32'd4);
        checkOutput("mult_after_rst_lo", 64'(lo_o), 64'd4);

        $display("[TB] accumulate opcodes");
        applyStimulus(1'b0, 1'b1, 4'd4, 32'h0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        applyStimulus(1'b0, 1'b1, 4'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        applyStimulus(1'b0, 1'b1, 4'd9, 32'd1, 32'd1, 1'b0, 1'b0, 32'd0, 32'd0);
`ifdef HILO_ACC_EN
        checkOutput("maddu_stall", 64'(sampStall), 64'd1);
        applyStimulus(1'b0, 1'b1, 4'd9, 32'd1, 32'd1, 1'b0, 1'b1, 32'd0, 32'd1);
        checkOutput("maddu_hilo", {hi_o, lo_o}, 64'h0000_0001_0000_0000);
        applyStimulus(1'b0, 1'b1, 4'd10, 32'd2, 32'd3, 1'b0, 1'b0, 32'd0, 32'd0);
        checkOutput("msub_signed", 64'(md_signed), 64'd1);
        applyStimulus(1'b0, 1'b1, 4'd10, 32'd2, 32'd3, 1'b0, 1'b1, 32'd0, 32'd6);
        checkOutput("msub_hilo", {hi_o, lo_o}, 64'h0000_0000_FFFF_FFFA);
`else
        checkOutput("op9_stall", 64'(sampStall), 64'd0);
        checkOutput("op9_busy", 64'(busy), 64'd0);
        checkOutput("op9_hilo", {hi_o, lo_o}, 64'h0000_0000_FFFF_FFFF);
`endif

        $display("[TB] randomized run");
        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 99) == 0);
            v   = ($urandom_range(0, 3) != 0);
            o   = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3))
                                              : 4'($urandom_range(0, 15));
            a   = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
            b   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            fl  = ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 3) == 0);
            res = mdCompute(md_mult, md_signed, md_a, md_b);
            applyStimulus(r, v, o, a, b, fl, rdy, res[63:32], res[31:0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
